// File: rtl/muldiv_sequencer_if.sv
// Decode <-> multiply/divide sequencer bundle: commands, operands, HI/LO reads and results.
// Latency: none (wires only).
// Backpressure: stallD travels in the slave->master direction and holds decode while busy.
// Ports: multiply/divide command encodings, srcA/srcB operands, mfhi/mflo reads;
//        hi/lo/busy/done/div_zero/stallD results. MULDIV_MTHILO_EN adds mthi/mtlo/wdata.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic [1:0]       multiply;
    logic [1:0]       divide;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             mfhi;
    logic             mflo;
`ifdef MULDIV_MTHILO_EN
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
`endif
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             stallD;

    modport master (
        output multiply, divide, srcA, srcB, mfhi, mflo,
`ifdef MULDIV_MTHILO_EN
        output mthi, mtlo, wdata,
`endif
        input  hi, lo, busy, done, div_zero, stallD
    );

    modport slave (
        input  multiply, divide, srcA, srcB, mfhi, mflo,
`ifdef MULDIV_MTHILO_EN
        input  mthi, mtlo, wdata,
`endif
        output hi, lo, busy, done, div_zero, stallD
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide owning the HI/LO register pair.
// Latency: WIDTH+2 edges from start to done (2 edges for divide by zero).
// Backpressure: stallD (combinational) holds decode on any HI/LO access or new start while busy.
// Ports: CLK, RST (async active-low), bus (muldiv_sequencer_if.slave).
// Optional: define MULDIV_MTHILO_EN to enable mthi/mtlo writes of wdata while idle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    muldiv_sequencer_if.slave    bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;       // multiplicand (MUL) or divisor (DIV) magnitude
    logic [2*WIDTH-1:0] acc;        // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic               is_div;
    logic               dz;         // divide by zero: acc already holds {srcA, all ones}
    logic               neg_lo;     // negate product / quotient at FIX
    logic               neg_hi;     // negate remainder at FIX (follows dividend)
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dz_q;

    // ---- start decode and operand magnitudes ----
    logic             start_mul, start_div, sgn, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign start_mul = bus.multiply[1];
    assign start_div = bus.divide[1] & ~start_mul;
    assign sgn       = start_mul ? bus.multiply[0] : bus.divide[0];
    assign a_neg     = sgn & bus.srcA[WIDTH-1];
    assign b_neg     = sgn & bus.srcB[WIDTH-1];
    assign abs_a     = a_neg ? -bus.srcA : bus.srcA;
    assign abs_b     = b_neg ? -bus.srcB : bus.srcB;
    assign b_zero    = (bus.srcB == '0);

    logic last_step;
    assign last_step = (cnt == CW'(WIDTH - 1));

    // ---- iteration datapath ----
    logic [WIDTH:0] mul_sum, div_shift, div_diff;
    logic           div_ok;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = ~div_diff[WIDTH];

    // ---- sign fix-up applied when writing HI/LO ----
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_lo ? -acc : acc;
    assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // ---- FSM ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_mul)      state_nxt = MUL;
                else if (start_div) state_nxt = b_zero ? FIX : DIV;
            end
            MUL, DIV: if (last_step) state_nxt = FIX;
            FIX:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // ---- datapath and architectural registers ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt    <= '0;
            opnd   <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    neg_lo <= a_neg ^ b_neg;
                    neg_hi <= a_neg;
                    if (start_mul) begin
                        opnd   <= abs_a;
                        acc    <= {{WIDTH{1'b0}}, abs_b};
                        is_div <= 1'b0;
                        dz     <= 1'b0;
                    end else if (start_div) begin
                        opnd   <= abs_b;
                        is_div <= 1'b1;
                        dz     <= b_zero;
                        acc    <= b_zero ? {bus.srcA, {WIDTH{1'b1}}}
                                         : {{WIDTH{1'b0}}, abs_a};
                    end
`ifdef MULDIV_MTHILO_EN
                    else begin
                        // A start in the same cycle wins; the move is simply dropped.
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
`endif
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                            acc[WIDTH-2:0], div_ok};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (dz) begin
                        hi_q <= acc[2*WIDTH-1:WIDTH];
                        lo_q <= acc[WIDTH-1:0];
                    end else if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
                    dz_q   <= dz;
                end
                default: ;
            endcase
        end
    end

    // ---- outputs ----
    logic hilo_access;
`ifdef MULDIV_MTHILO_EN
    assign hilo_access = bus.mfhi | bus.mflo | bus.multiply[1] | bus.divide[1] | bus.mthi | bus.mtlo;
`else
    assign hilo_access = bus.mfhi | bus.mflo | bus.multiply[1] | bus.divide[1];
`endif

    assign bus.busy     = (state != IDLE);
    assign bus.stallD   = bus.busy & hilo_access;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide controller owning the HI/LO register pair of the pipelined MIPS core. Accepts the decode-stage `multiply`/`divide` command encoding and operands, and runs an iterative shift-add multiply or restoring divide over WIDTH cycles. Stalls decode via `stallD` when a dependent or new HI/LO operation arrives while busy. Replaces the combinational mult/div path in decode.

## Interface
- WIDTH, 32, operand width; HI/LO each WIDTH bits.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- multiply  in  2  [1] start multiply, [0] signed.
- divide  in  2  [1] start divide, [0] signed.
- srcA  in  WIDTH  multiplicand / dividend (rd1D).
- srcB  in  WIDTH  multiplier / divisor (rd2D).
- mfhi, mflo  in  1  decode-stage read of HI / LO this cycle.
- hi, lo  out  WIDTH  architectural HI/LO registers.
- busy  out  1  operation in flight (state ≠ IDLE).
- done  out  1  one-cycle pulse, cycle after HI/LO written.
- div_zero  out  1  one-cycle pulse alongside `done` for a divide with srcB = 0.
- stallD  out  1  combinational: busy & (mfhi | mflo | multiply[1] | divide[1] [| mthi | mtlo]).

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE: `multiply[1]` → MUL; else `divide[1]` → DIV (multiply wins if both asserted; divide dropped). Latch operand magnitudes (two's-complement abs if the sign bit is set and signed), result-sign flags, clear the iteration counter.
- Divide with srcB = 0 → FIX directly, no iterations.
- MUL: one shift-add step per cycle on a 2·WIDTH accumulator; WIDTH steps → FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); WIDTH steps → FIX.
- FIX: apply sign, write HI/LO, → IDLE. `done` high during the following IDLE cycle.
- Multiply result: {hi, lo} = full 2·WIDTH product; signed negates when operand signs differ.
- Divide result: lo = quotient truncated toward zero; hi = remainder, sign follows dividend.
- Signed most-negative / −1: lo = 0x80000000, hi = 0 (magnitude wrap, no trap).
- Divide by zero: hi = srcA, lo = all ones, `div_zero` pulses.
- Starts arriving while busy are ignored. `stallD` holds decode, so the command re-presents in IDLE.
- hi/lo stay stable during MUL/DIV and change only at the FIX edge.

## Timing
- Reset (async, RST = 0): state IDLE, hi = lo = 0, busy = 0, done = 0, div_zero = 0, counter 0. Reset mid-operation aborts; no partial result is written.
- Normal op: start sampled at edge E0. busy high from E0 through edge E0+WIDTH+1 (FIX write). hi/lo valid after E0+WIDTH+1. done high the cycle after. Latency WIDTH+2 edges (34 at WIDTH = 32).
- Divide by zero: FIX at E0+1, result visible after E0+1, done pulse next cycle.
- stallD is combinational from inputs and busy. It is low in IDLE, so a back-to-back start is accepted in the same cycle `done` is high.
- mfhi/mflo in the cycle `done` is high read the new value (stallD low).

## Configuration
- MULDIV_MTHILO_EN defined: adds ports `mthi`, `mtlo` (in, 1) and `wdata` (in, WIDTH). In IDLE, mthi/mtlo write `wdata` to hi/lo at the next edge. A start in the same cycle takes priority, and the move is dropped. When busy, they assert stallD.
- Undefined: ports absent; hi/lo written only by FIX.

## Test plan
- Unsigned multiply: srcA = 7, srcB = 6, multiply = 2'b10 → after 34 edges hi = 0, lo = 42, done pulses once, busy low.
- Signed multiply: srcA = −3, srcB = 5, multiply = 2'b11 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
- Signed divide: srcA = −7, srcB = 2, divide = 2'b11 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Also srcA = 0x80000000, srcB = −1 → lo = 0x80000000, hi = 0.
- Divide by zero: srcA = 0x1234, srcB = 0, divide = 2'b10 → after 2 edges hi = 0x1234, lo = 0xFFFFFFFF, div_zero and done pulse together.
- Hazard: assert mflo at cycle 5 of a multiply → stallD = 1 until FIX completes; new multiply while busy ignored, then accepted in the done cycle.
- Reset: drop RST at cycle 10 of a divide → immediately hi = lo = 0, busy = 0. After release, a fresh divide 100/7 → lo = 14, hi = 2.
